// File: rtl/uart_word_loader.sv
// uart_word_loader: 8N1 UART receiver that packs bytes little-endian into
// 32-bit words. Each completed word leaves as a one-cycle write strobe with
// its byte address. An idle timeout flushes any partial word and raises done.
module uart_word_loader #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int ADDR_STEP    = 4,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        fpga_clk,
    input  logic        reset_n,
    input  logic        rx,
    output logic [31:0] data_out,
    output logic [31:0] addr_out,
    output logic        wr_en,
    output logic        done,
    output logic        frame_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [31:0] IDLE_LIMIT = 32'(TIMEOUT_BITS * CLKS_PER_BIT);
    localparam logic [31:0] STEP       = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and start-edge detection
    // ------------------------------------------------------------------
    logic       rx_meta_reg;
    logic       rx_s_reg;
    logic       rx_prev_reg;
    logic [2:0] warm_reg;
    logic       rx_fall;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    // warm_reg marks when rx_prev_reg holds a genuine line sample rather than
    // the reset preset, so a line held low across reset release is not seen
    // as a falling edge.
    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
            warm_reg    <= 3'b000;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
            warm_reg    <= {warm_reg[1:0], 1'b1};
        end
    end

    assign rx_fall = warm_reg[2] & rx_prev_reg & ~rx_s_reg;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t        state_reg,   state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg,   shift_next;
    logic             byte_valid;
    logic             byte_bad;
    logic             start_entry;

    logic        got_byte_reg;
    logic        done_reg;
    logic        pend_done_reg;
    logic [31:0] idle_cnt_reg;
    logic        timeout_hit;
    logic        frozen;

    assign timeout_hit = (state_reg == ST_IDLE) && got_byte_reg && !done_reg &&
                         !pend_done_reg && (idle_cnt_reg == IDLE_LIMIT);
    assign frozen      = done_reg | pend_done_reg | timeout_hit;

    // FSM state register and bit timing counters.
    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= 3'd0;
            shift_reg   <= 8'h00;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    // Next-state logic: mid-bit sampling of start, data and stop bits.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        byte_valid   = 1'b0;
        byte_bad     = 1'b0;
        start_entry  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!frozen && rx_fall) begin
                    state_next   = ST_START;
                    bit_cnt_next = '0;
                    start_entry  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_cnt_reg == BIT_HALF) begin
                    bit_cnt_next = '0;
                    bit_idx_next = 3'd0;
                    // A high line at mid start bit was only a glitch.
                    state_next   = rx_s_reg ? ST_IDLE : ST_DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next = '0;
                    shift_next   = {rx_s_reg, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next = '0;
                    // Leave mid stop bit so a following start bit is not missed.
                    state_next   = ST_IDLE;
                    byte_valid   = rx_s_reg;
                    byte_bad     = ~rx_s_reg;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Idle timeout counter
    // ------------------------------------------------------------------
    // Counts idle cycles once at least one good byte has arrived; any new
    // start bit restarts the count, so it can never fire alongside byte_valid.
    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            idle_cnt_reg <= 32'd0;
        end else if (start_entry) begin
            idle_cnt_reg <= 32'd0;
        end else if ((state_reg == ST_IDLE) && got_byte_reg && !done_reg &&
                     !pend_done_reg && (idle_cnt_reg != IDLE_LIMIT)) begin
            idle_cnt_reg <= idle_cnt_reg + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Word packing
    // ------------------------------------------------------------------
    logic [31:0] word_reg;
    logic [31:0] word_next;
    logic [1:0]  lane_reg;
    logic [31:0] addr_cnt_reg;
    logic [31:0] data_out_reg;
    logic [31:0] addr_out_reg;
    logic        wr_en_reg;
    logic        frame_err_reg;

    // Each byte lane takes the received byte only when it is the active lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[8*gi +: 8] = (byte_valid && (lane_reg == 2'(gi))) ?
                                          shift_reg : word_reg[8*gi +: 8];
        end
    endgenerate

    // Lane/address bookkeeping, write strobe, timeout flush and sticky flags.
    always_ff @(posedge fpga_clk) begin
        if (!reset_n) begin
            word_reg      <= 32'd0;
            lane_reg      <= 2'd0;
            addr_cnt_reg  <= 32'd0;
            data_out_reg  <= 32'd0;
            addr_out_reg  <= 32'd0;
            wr_en_reg     <= 1'b0;
            pend_done_reg <= 1'b0;
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            got_byte_reg  <= 1'b0;
        end else begin
            wr_en_reg <= 1'b0;
            if (pend_done_reg) begin
                done_reg <= 1'b1;
            end
            if (byte_bad) begin
                frame_err_reg <= 1'b1;
            end
            if (byte_valid) begin
                got_byte_reg <= 1'b1;
                if (lane_reg == 2'd3) begin
                    data_out_reg <= word_next;
                    addr_out_reg <= addr_cnt_reg;
                    addr_cnt_reg <= addr_cnt_reg + STEP;
                    wr_en_reg    <= 1'b1;
                    word_reg     <= 32'd0;
                    lane_reg     <= 2'd0;
                end else begin
                    word_reg <= word_next;
                    lane_reg <= lane_reg + 2'd1;
                end
            end else if (timeout_hit) begin
                if (lane_reg != 2'd0) begin
                    // Flush the partial word; unfilled lanes are already zero.
                    data_out_reg  <= word_reg;
                    addr_out_reg  <= addr_cnt_reg;
                    addr_cnt_reg  <= addr_cnt_reg + STEP;
                    wr_en_reg     <= 1'b1;
                    word_reg      <= 32'd0;
                    lane_reg      <= 2'd0;
                    pend_done_reg <= 1'b1;
                end else begin
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign data_out  = data_out_reg;
    assign addr_out  = addr_out_reg;
    assign wr_en     = wr_en_reg;
    assign done      = done_reg;
    assign frame_err = frame_err_reg;

endmodule
